fetch_responder: RTL
====================

Name: fetch_responder

Overview:
Responder side of the fetch/req/ack/cache_hit/data_ready handshake; answers an initiator's fetch from a small direct-mapped line store.
- Hit: cache_hit in the fetch cycle, then data_ready one cycle later.
- Miss: initiator holds req with fetch; block issues a backing read and returns ack/data_ready exactly MISS_LAT cycles after the fetch.
- Sits between the fetch initiator and the backing memory.

Parameters:
ADDR_W, 8, fetch address width
DATA_W, 32, line data width
LINES, 4, number of direct-mapped lines (power of 2, >=2)
MISS_LAT, 3, fetch-to-ack latency on miss; legal 1..5, elaboration error otherwise

Ports:
clk  input  1  clock, rising edge
rst  input  1  reset, asynchronous, active-high
fetch  input  1  fetch request, single-cycle strobe
addr  input  ADDR_W  fetch address, valid with fetch
req  input  1  initiator miss request; must accompany fetch on miss
cache_hit  output  1  lookup hit, combinational, same cycle as accepted fetch
ack  output  1  miss acknowledge, one-cycle pulse
data_ready  output  1  rdata valid, one-cycle pulse
done  output  1  transaction complete, one-cycle pulse, coincident with data_ready
rdata  output  DATA_W  returned data, held until next data_ready
busy  output  1  transaction in flight; fetch ignored while high
proto_err  output  1  one-cycle pulse: miss fetch without req
mem_rd  output  1  backing read strobe, one cycle
mem_addr  output  ADDR_W  backing read address, valid with mem_rd
mem_rdata  input  DATA_W  backing data, sampled on ack cycle

Behaviour:
- Reset (async, rst=1):
  - state IDLE; all valid bits cleared; latency counter 0.
  - cache_hit, ack, data_ready, done, busy, proto_err, mem_rd, mem_addr and rdata all 0.
- Address split: index = addr[clog2(LINES)-1:0]; tag = remaining upper bits.
- States: IDLE, HIT_DATA, MISS_WAIT.
- IDLE:
  - fetch accepted only in IDLE. cache_hit = fetch & valid[index] & tag match.
  - Hit -> HIT_DATA.
  - Miss with req=1 -> mem_rd=1 and mem_addr=addr in the fetch cycle (registered outputs; observed on the edge after). Address is latched and counter loaded. -> MISS_WAIT.
  - Miss with req=0 -> proto_err pulse next cycle; no fill; stay IDLE.
- HIT_DATA (busy=1): data_ready=1, done=1, rdata=line data. -> IDLE. Back-to-back hits at most every 2 cycles.
- MISS_WAIT (busy=1):
  - Counter decrements. ack, data_ready and done all assert in the cycle exactly MISS_LAT cycles after the fetch cycle.
  - On that cycle: rdata=mem_rdata; line written (tag, data, valid=1), overwriting any occupant. -> IDLE.
- busy: 1 in HIT_DATA and MISS_WAIT, including the done cycle. fetch in any non-IDLE cycle (including the done cycle) is ignored silently, with no cache_hit and no proto_err.
- req outside an accepted miss fetch: ignored.
- Reset mid-MISS_WAIT: transaction aborted, no ack, line not filled.
- Guarantees: ack never occurs without a prior accepted miss; data_ready never follows a hit by other than 1 cycle.

Optional Feature:
FETCH_RESP_SVA_EN
- Defined: embedded concurrent assertions, disabled iff rst:
  - hit implies data_ready next cycle;
  - accepted miss implies ack at ##MISS_LAT;
  - ack implies data_ready and done in the same cycle;
  - no ack while IDLE;
  - onehot0 of {cache_hit, ack}.
- Undefined: no assertions; RTL identical.

Decomposition:
- Package fetch_resp_pkg:
  - state enum (IDLE, HIT_DATA, MISS_WAIT);
  - MISS_LAT_MIN=1, MISS_LAT_MAX=5;
  - counter width constant (3 bits);
  - helper functions for index/tag widths.
- Sub-module fetch_resp_linestore: tag/data/valid arrays with a combinational read port, a single write port and async clear on rst.

Test Plan:
1. Reset; MISS_LAT=3; fetch+req addr 0x14, mem_rdata 0xDEADBEEF -> cache_hit 0, mem_rd with mem_addr 0x14, ack/data_ready/done at fetch+3, rdata 0xDEADBEEF, busy low next cycle.
2. Fetch 0x14 again -> cache_hit=1 same cycle, data_ready/done next cycle with rdata 0xDEADBEEF; no ack, no mem_rd.
3. Fetch+req 0x24 (same index 0), mem_rdata 0x12345678 -> miss and fill; then fetch+req 0x14 -> cache_hit 0 (evicted), ack at +3.
4. Fetch 0x30 at fetch+1 of an outstanding miss -> ignored: no cache_hit, no mem_rd, no proto_err; original ack still at +3.
5. Assert rst at fetch+2 of a miss on 0x14 -> no ack; then fetch+req 0x14 -> miss (valid cleared).
6. Miss fetch 0x50 with req=0 -> proto_err pulse next cycle, no mem_rd, no ack, busy stays 0; a following fetch of 0x50 still misses.

Source files
------------

// File: rtl/fetch_resp_pkg.sv
// Shared types and constants for the fetch responder.
// Optional embedded assertions are enabled with the FETCH_RESP_SVA_EN macro.
package fetch_resp_pkg;

   typedef enum logic [1:0] {
      IDLE      = 2'd0,
      HIT_DATA  = 2'd1,
      MISS_WAIT = 2'd2
   } state_e;

   localparam int MISS_LAT_MIN = 1;
   localparam int MISS_LAT_MAX = 5;
   localparam int CNT_W        = 3;

   function automatic int idx_w(input int lines);
      return (lines > 1) ? $clog2(lines) : 1;
   endfunction

   function automatic int tag_w(input int addr_w, input int lines);
      return addr_w - idx_w(lines);
   endfunction

endpackage

// File: rtl/fetch_resp_linestore.sv
// Direct-mapped tag/data/valid store: one combinational read port,
// one synchronous write port, all entries cleared on reset.
module fetch_resp_linestore
   import fetch_resp_pkg::*;
#(
   parameter int LINES  = 4,
   parameter int IDX_W  = 2,
   parameter int TAG_W  = 6,
   parameter int DATA_W = 32
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [IDX_W-1:0]  rd_idx,
   output logic [TAG_W-1:0]  rd_tag,
   output logic [DATA_W-1:0] rd_data,
   output logic              rd_valid,
   input  logic              wr_en,
   input  logic [IDX_W-1:0]  wr_idx,
   input  logic [TAG_W-1:0]  wr_tag,
   input  logic [DATA_W-1:0] wr_data
);

   logic [TAG_W-1:0]  tag_q   [LINES];
   logic [DATA_W-1:0] data_q  [LINES];
   logic [LINES-1:0]  valid_q;

   // Line storage: cleared on reset, single fill port.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < LINES; i++) begin
            tag_q[i]  <= '0;
            data_q[i] <= '0;
         end
         valid_q <= '0;
      end else if (wr_en) begin
         tag_q[wr_idx]   <= wr_tag;
         data_q[wr_idx]  <= wr_data;
         valid_q[wr_idx] <= 1'b1;
      end else begin
         valid_q <= valid_q;
      end
   end

   assign rd_tag   = tag_q[rd_idx];
   assign rd_data  = data_q[rd_idx];
   assign rd_valid = valid_q[rd_idx];

endmodule

// File: rtl/fetch_responder.sv
// Responder for the fetch/req/ack/cache_hit/data_ready handshake.
// Define FETCH_RESP_SVA_EN to enable embedded protocol assertions.
module fetch_responder
   import fetch_resp_pkg::*;
#(
   parameter int ADDR_W   = 8,
   parameter int DATA_W   = 32,
   parameter int LINES    = 4,
   parameter int MISS_LAT = 3
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              fetch,
   input  logic [ADDR_W-1:0] addr,
   input  logic              req,
   output logic              cache_hit,
   output logic              ack,
   output logic              data_ready,
   output logic              done,
   output logic [DATA_W-1:0] rdata,
   output logic              busy,
   output logic              proto_err,
   output logic              mem_rd,
   output logic [ADDR_W-1:0] mem_addr,
   input  logic [DATA_W-1:0] mem_rdata
);

   localparam int IDX_W = idx_w(LINES);
   localparam int TAG_W = tag_w(ADDR_W, LINES);

   if (MISS_LAT < MISS_LAT_MIN || MISS_LAT > MISS_LAT_MAX) begin : g_bad_lat
      $error("fetch_responder: MISS_LAT out of range 1..5");
   end

   state_e              state_q, state_d;
   logic [CNT_W-1:0]    cnt_q, cnt_d;
   logic                mem_rd_q, mem_rd_d;
   logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;
   logic                proto_err_q, proto_err_d;
   logic [DATA_W-1:0]   rdata_q, rdata_d;

   logic [TAG_W-1:0]    rd_tag_s;
   logic [DATA_W-1:0]   rd_data_s;
   logic                rd_valid_s;
   logic                hit_s;
   logic                ack_s;

   fetch_resp_linestore #(
      .LINES (LINES),
      .IDX_W (IDX_W),
      .TAG_W (TAG_W),
      .DATA_W(DATA_W)
   ) u_store (
      .clk     (clk),
      .rst     (rst),
      .rd_idx  (addr[IDX_W-1:0]),
      .rd_tag  (rd_tag_s),
      .rd_data (rd_data_s),
      .rd_valid(rd_valid_s),
      .wr_en   (ack_s),
      .wr_idx  (mem_addr_q[IDX_W-1:0]),
      .wr_tag  (mem_addr_q[ADDR_W-1:IDX_W]),
      .wr_data (mem_rdata)
   );

   assign hit_s = fetch && (state_q == IDLE) && rd_valid_s &&
                  (rd_tag_s == addr[ADDR_W-1:IDX_W]);
   // Counter reaches zero exactly MISS_LAT cycles after the fetch cycle.
   assign ack_s = (state_q == MISS_WAIT) && (cnt_q == {CNT_W{1'b0}});

   // Next-state and registered-output decode.
   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      mem_rd_d    = 1'b0;
      mem_addr_d  = mem_addr_q;
      proto_err_d = 1'b0;
      rdata_d     = rdata_q;
      case (state_q)
         IDLE: begin
            if (fetch) begin
               if (hit_s) begin
                  rdata_d = rd_data_s;
                  state_d = HIT_DATA;
               end else if (req) begin
                  mem_rd_d   = 1'b1;
                  mem_addr_d = addr;
                  cnt_d      = CNT_W'(MISS_LAT - 1);
                  state_d    = MISS_WAIT;
               end else begin
                  proto_err_d = 1'b1;
               end
            end else begin
               state_d = IDLE;
            end
         end
         HIT_DATA: begin
            state_d = IDLE;
         end
         MISS_WAIT: begin
            if (ack_s) begin
               rdata_d = mem_rdata;
               state_d = IDLE;
            end else begin
               cnt_d = cnt_q - CNT_W'(1);
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // State and output registers.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= IDLE;
         cnt_q       <= {CNT_W{1'b0}};
         mem_rd_q    <= 1'b0;
         mem_addr_q  <= {ADDR_W{1'b0}};
         proto_err_q <= 1'b0;
         rdata_q     <= {DATA_W{1'b0}};
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         mem_rd_q    <= mem_rd_d;
         mem_addr_q  <= mem_addr_d;
         proto_err_q <= proto_err_d;
         rdata_q     <= rdata_d;
      end
   end

   assign cache_hit  = hit_s;
   assign ack        = ack_s;
   assign data_ready = (state_q == HIT_DATA) || ack_s;
   assign done       = data_ready;
   // Miss data is forwarded in the ack cycle, then held in rdata_q.
   assign rdata      = ack_s ? mem_rdata : rdata_q;
   assign busy       = (state_q != IDLE);
   assign proto_err  = proto_err_q;
   assign mem_rd     = mem_rd_q;
   assign mem_addr   = mem_addr_q;

`ifdef FETCH_RESP_SVA_EN
   a_hit_dr: assert property (@(posedge clk) disable iff (rst)
      cache_hit |=> data_ready);
   a_miss_ack: assert property (@(posedge clk) disable iff (rst)
      (fetch && state_q == IDLE && !cache_hit && req) |-> ##MISS_LAT ack);
   a_ack_dr: assert property (@(posedge clk) disable iff (rst)
      ack |-> (data_ready && done));
   a_no_idle_ack: assert property (@(posedge clk) disable iff (rst)
      (state_q == IDLE) |-> !ack);
   a_onehot: assert property (@(posedge clk) disable iff (rst)
      $onehot0({cache_hit, ack}));
`else
`endif

endmodule
